// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmit path.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// CPU-side write/status bus of the UART transmit FIFO.
interface uart_tx_fifo_if
  import uart_pkg::*;
#(
  parameter int DEPTH = 8
);

  logic                      wr_en;
  logic [UART_DATA_BITS-1:0] wr_data;
  logic                      clr_overflow;
  logic                      full;
  logic                      empty;
  logic [$clog2(DEPTH):0]    level;
  logic                      overflow;

  modport master (
    output wr_en, wr_data, clr_overflow,
    input  full, empty, level, overflow
  );

  modport slave (
    input  wr_en, wr_data, clr_overflow,
    output full, empty, level, overflow
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: rd_data always presents the head entry.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      level_reg;
  logic             wr_ok;
  logic             rd_ok;

  // A write while full is dropped even if a pop happens in the same cycle.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   level_reg <= level_reg + (AW+1)'(1);
        2'b01:   level_reg <= level_reg - (AW+1)'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr_reg];
  assign full    = (level_reg == (AW+1)'(DEPTH));
  assign empty   = (level_reg == '0);
  assign level   = level_reg;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO drained by a serializer running at a
// per-frame baud period (clocks per bit).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int BAUD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BAUD_W-1:0] baud_period,
  uart_tx_fifo_if.slave     bus,
  output logic              busy,
  output logic              tx_done,
  output logic              TX
);

  localparam int                IDX_W    = $clog2(UART_DATA_BITS);
  localparam logic [IDX_W-1:0]  LAST_BIT = IDX_W'(UART_DATA_BITS - 1);

  uart_tx_state_t            state_reg, state_next;
  logic [UART_DATA_BITS-1:0] shift_reg, shift_next;
  logic [UART_DATA_BITS-1:0] fifo_rd_data;
  logic [BAUD_W-1:0]         bp_reg, bp_next;
  logic [BAUD_W-1:0]         cnt_reg, cnt_next;
  logic [BAUD_W-1:0]         bp_sel;
  logic [IDX_W-1:0]          bit_idx_reg, bit_idx_next;
  logic                      tx_reg, tx_next;
  logic                      overflow_reg;
  logic                      bit_end;
  logic                      load;
  logic                      pop;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (bus.wr_en),
    .wr_data (bus.wr_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (bus.full),
    .empty   (bus.empty),
    .level   (bus.level)
  );

  // Dropped write beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_reg <= 1'b0;
    end else if (bus.wr_en && bus.full) begin
      overflow_reg <= 1'b1;
    end else if (bus.clr_overflow) begin
      overflow_reg <= 1'b0;
    end
  end

  assign bus.overflow = overflow_reg;

  assign bp_sel  = (baud_period == '0) ? BAUD_W'(1) : baud_period;
  assign bit_end = (cnt_reg == bp_reg - BAUD_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bp_reg      <= BAUD_W'(1);
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      tx_reg      <= 1'b1;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bp_reg      <= bp_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      tx_reg      <= tx_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bp_next      = bp_reg;
    cnt_next     = cnt_reg;
    bit_idx_next = bit_idx_reg;
    load         = 1'b0;
    tx_done      = 1'b0;
    tx_next      = 1'b1;

    case (state_reg)
      IDLE: begin
        load = !bus.empty;
      end
      START: begin
        if (bit_end) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          state_next   = DATA;
        end else begin
          cnt_next = cnt_reg + BAUD_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_next   = '0;
          shift_next = shift_reg >> 1;
          if (bit_idx_reg == LAST_BIT) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx_reg + IDX_W'(1);
          end
        end else begin
          cnt_next = cnt_reg + BAUD_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          tx_done    = 1'b1;
          cnt_next   = '0;
          state_next = IDLE;
          load       = !bus.empty;
        end else begin
          cnt_next = cnt_reg + BAUD_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    // Popping the next byte overrides the IDLE return so frames run gap-free.
    if (load) begin
      shift_next = fifo_rd_data;
      bp_next    = bp_sel;
      cnt_next   = '0;
      state_next = START;
    end

    // TX is registered, so it is derived from where the FSM is going.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  assign pop  = load;
  assign busy = (state_reg != IDLE);
  assign TX   = tx_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: queue-level reference model plus a UART line decoder.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int DEPTH  = 8;
  localparam int BAUD_W = 32;

  typedef struct {
    logic [7:0]  data;
    int unsigned bp;
    int unsigned start;
  } frame_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [BAUD_W-1:0] baud;
  logic              busy;
  logic              tx_done;
  logic              tx;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int unsigned cyc = 0;
  int unsigned m_left = 0;
  bit          m_ovf = 1'b0;
  logic [7:0]  mq[$];
  frame_t      exp_q[$];

  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(
    .DEPTH  (DEPTH),
    .BAUD_W (BAUD_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .baud_period (baud),
    .bus         (bus),
    .busy        (busy),
    .tx_done     (tx_done),
    .TX          (tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, want);
    end
  endtask

  // Model: a frame occupies UART_FRAME_BITS*bp clocks; the next queued byte is taken
  // at the edge that ends the current frame (or the first edge it is seen while idle).
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        exp_q.delete();
        m_left = 0;
        m_ovf  = 1'b0;
      end else begin
        automatic bit          full_pre = (mq.size() == DEPTH);
        automatic bit          ne_pre   = (mq.size() != 0);
        automatic int unsigned bp;
        cyc++;
        if (m_left > 0) m_left--;
        if (m_left == 0 && ne_pre) begin
          bp = (baud == 0) ? 1 : int'(baud);
          m_left = UART_FRAME_BITS * bp;
          exp_q.push_back('{data: mq.pop_front(), bp: bp, start: cyc});
        end
        if (bus.wr_en && !full_pre) mq.push_back(bus.wr_data);
        if (bus.wr_en && full_pre) m_ovf = 1'b1;
        else if (bus.clr_overflow) m_ovf = 1'b0;
      end
    end
  end

  // Per-cycle status check against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("tx_done",  32'(tx_done),      32'(m_left == 1));
      chk("busy",     32'(busy),         32'(m_left != 0));
      chk("level",    32'(bus.level),    32'(mq.size()));
      chk("full",     32'(bus.full),     32'(mq.size() == DEPTH));
      chk("empty",    32'(bus.empty),    32'(mq.size() == 0));
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    end
  end

  // Line monitor: each falling edge of TX starts a frame, decoded at mid-bit points.
  initial begin
    frame_t      f;
    logic [9:0]  got;
    logic [9:0]  want;
    int unsigned t0;
    bit          abort;
    forever begin
      @(negedge clk);
      if (rst_n && tx == 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 32'(1), 32'(0));
        end else begin
          f = exp_q.pop_front();
          t0 = cyc;
          abort = 1'b0;
          got = '1;
          chk("frame_start", t0, f.start);
          for (int k = 0; k < UART_FRAME_BITS && !abort; k++) begin
            while (cyc < t0 + k * f.bp + f.bp / 2 && !abort) begin
              @(negedge clk);
              if (!rst_n) abort = 1'b1;
            end
            if (!abort) got[k] = tx;
          end
          if (!abort) begin
            want = {1'b1, f.data, 1'b0};
            chk("frame_bits", 32'(got), 32'(want));
          end
          while (!abort && cyc < t0 + UART_FRAME_BITS * f.bp - 1) begin
            @(negedge clk);
            if (!rst_n) abort = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic drive(input bit we, input logic [7:0] d, input bit clr);
    @(negedge clk);
    bus.wr_en        = we;
    bus.wr_data      = d;
    bus.clr_overflow = clr;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(m_left == 0 && mq.size() == 0 && exp_q.size() == 0) && n < 3000) begin
      drive(1'b0, 8'h00, 1'b0);
      n++;
    end
    chk("idle_timeout", 32'(n >= 3000), 32'(0));
    repeat (3) drive(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    bus.wr_en        = 1'b0;
    bus.wr_data      = 8'h00;
    bus.clr_overflow = 1'b0;
    baud             = 4;
    rst_n            = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx",       32'(tx),           32'(1));
    chk("rst_busy",     32'(busy),         32'(0));
    chk("rst_empty",    32'(bus.empty),    32'(1));
    chk("rst_level",    32'(bus.level),    32'(0));
    chk("rst_overflow", 32'(bus.overflow), 32'(0));
    rst_n = 1'b1;

    // Single byte
    drive(1'b1, 8'hA5, 1'b0);
    wait_idle();

    // Back-to-back frames
    drive(1'b1, 8'h00, 1'b0);
    drive(1'b1, 8'hFF, 1'b0);
    drive(1'b1, 8'h55, 1'b0);
    wait_idle();

    // Overflow burst
    for (int i = 0; i < 12; i++) drive(1'b1, 8'($urandom), 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    chk("burst_level",    32'(bus.level),    32'(8));
    chk("burst_overflow", 32'(bus.overflow), 32'(1));
    wait_idle();
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    chk("clr_overflow", 32'(bus.overflow), 32'(0));

    // Baud change during the first of two frames
    drive(1'b1, 8'($urandom), 1'b0);
    drive(1'b1, 8'($urandom), 1'b0);
    repeat (10) drive(1'b0, 8'h00, 1'b0);
    baud = 8;
    wait_idle();
    baud = 4;

    // Reset during DATA bit 3, then a clean frame
    drive(1'b1, 8'hE7, 1'b0);
    drive(1'b1, 8'h12, 1'b0);
    repeat (17) drive(1'b0, 8'h00, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tx",    32'(tx),        32'(1));
    chk("midrst_level", 32'(bus.level), 32'(0));
    chk("midrst_empty", 32'(bus.empty), 32'(1));
    chk("midrst_busy",  32'(busy),      32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 8'h3C, 1'b0);
    wait_idle();

    // baud_period = 0 runs at one clock per bit
    baud = 0;
    drive(1'b1, 8'h81, 1'b0);
    wait_idle();

    // Random traffic with random baud changes and overflow clears
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) baud = $urandom_range(0, 5);
      drive($urandom_range(0, 5) == 0, 8'($urandom), $urandom_range(0, 29) == 0);
    end
    baud = 2;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
